// File: rtl/bp_arb2.sv
// bp_arb2: two-requester arbiter in front of one BytePipe target. A transaction, or a
// burst-init write plus the burst it arms, is never interleaved. Option: BP_ARB2_ROUNDROBIN_EN.
module bp_arb2 #(
    parameter bit LOCK_BURST = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cg,
    input  logic [7:0] i_req0_data,
    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    output logic [7:0] o_req0_data,
    output logic       o_req0_valid,
    input  logic       i_req0_ready,
    input  logic [7:0] i_req1_data,
    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    output logic [7:0] o_req1_data,
    output logic       o_req1_valid,
    input  logic       i_req1_ready,
    output logic [7:0] o_tgt_data,
    output logic       o_tgt_valid,
    input  logic       i_tgt_ready,
    input  logic [7:0] i_tgt_data,
    input  logic       i_tgt_valid,
    output logic       o_tgt_ready,
    output logic       o_owner,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_RESP  = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       wr_q, wr_d;
    logic       a0_q, a0_d;
    logic [7:0] burst_q, burst_d;
    logic [8:0] wcnt_q, wcnt_d;
    logic [8:0] rcnt_q, rcnt_d;

    logic       tie_sel;
    logic       pick;
    logic       grant;
    logic       sel_valid;
    logic       sel_rready;
    logic [7:0] sel_data;
    logic       fwd_en;
    logic       rsp_en;
    logic       req_acc;
    logic       rsp_acc;
    logic [8:0] cnt_init;

`ifdef BP_ARB2_ROUNDROBIN_EN
    logic rr_q, rr_d;
    assign tie_sel = rr_q;
`else
    assign tie_sel = 1'b0;
`endif

    // Grant: live pick while idle, otherwise frozen on the transaction owner.
    always_comb begin
        pick = 1'b0;
        if (i_req0_valid && i_req1_valid)
            pick = tie_sel;
        else if (i_req1_valid)
            pick = 1'b1;
        grant      = (state_q == S_IDLE) ? pick : owner_q;
        sel_valid  = grant ? i_req1_valid : i_req0_valid;
        sel_data   = grant ? i_req1_data  : i_req0_data;
        sel_rready = grant ? i_req1_ready : i_req0_ready;
        cnt_init   = {1'b0, (sel_data[6:0] != 7'd0) ? burst_q : 8'd0} + 9'd1;
    end

    // Handshakes only happen on enabled cycles so no transfer escapes the counters.
    always_comb begin
        fwd_en       = i_cg && (state_q != S_RESP);
        rsp_en       = i_cg && (state_q == S_RESP);
        o_tgt_valid  = fwd_en && sel_valid;
        o_tgt_data   = sel_data;
        o_req0_ready = fwd_en && !grant && i_tgt_ready;
        o_req1_ready = fwd_en &&  grant && i_tgt_ready;
        o_tgt_ready  = rsp_en && sel_rready;
        o_req0_valid = rsp_en && !grant && i_tgt_valid;
        o_req1_valid = rsp_en &&  grant && i_tgt_valid;
        o_req0_data  = i_tgt_data;
        o_req1_data  = i_tgt_data;
        o_owner      = owner_q;
        o_busy       = (state_q != S_IDLE);
    end

    assign req_acc = o_tgt_valid && i_tgt_ready;
    assign rsp_acc = o_tgt_ready && i_tgt_valid;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        a0_d    = a0_q;
        burst_d = burst_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
`ifdef BP_ARB2_ROUNDROBIN_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            S_IDLE, S_LOCK: begin
                if (req_acc) begin
                    owner_d = grant;
                    wr_d    = sel_data[7];
                    a0_d    = (sel_data[6:0] == 7'd0);
                    if (sel_data[7]) begin
                        state_d = S_WDATA;
                        wcnt_d  = cnt_init;
                    end else begin
                        state_d = S_RESP;
                        rcnt_d  = cnt_init;
                    end
                end
            end
            S_WDATA: begin
                if (req_acc) begin
                    if (a0_q)
                        burst_d = sel_data;
                    wcnt_d = wcnt_q - 9'd1;
                    if (wcnt_q == 9'd1) begin
                        state_d = S_RESP;
                        rcnt_d  = 9'd1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_acc) begin
                    rcnt_d = rcnt_q - 9'd1;
                    if (rcnt_q == 9'd1) begin
                        if (!a0_q)
                            burst_d = 8'd0;
                        // A nonzero burst-init keeps the same owner for the txn it arms.
                        if (LOCK_BURST && wr_q && a0_q && (burst_q != 8'd0)) begin
                            state_d = S_LOCK;
                        end else begin
                            state_d = S_IDLE;
`ifdef BP_ARB2_ROUNDROBIN_EN
                            rr_d    = !owner_q;
`endif
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            a0_q    <= 1'b0;
            burst_q <= 8'd0;
            wcnt_q  <= 9'd0;
            rcnt_q  <= 9'd0;
`ifdef BP_ARB2_ROUNDROBIN_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            a0_q    <= a0_d;
            burst_q <= burst_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
`ifdef BP_ARB2_ROUNDROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_bp_arb2.sv
// Bench for bp_arb2: requester byte queues, a framing-aware target model and directed
// plus randomized scenarios checked against transaction-level expectations.
module tb_bp_arb2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cg  = 1'b1;
    logic [7:0] rq0_d = 8'd0, rq1_d = 8'd0, tg_d_in = 8'd0;
    logic rq0_v = 1'b0, rq1_v = 1'b0, rq0_rin = 1'b0, rq1_rin = 1'b0;
    logic tg_rdy_in = 1'b0, tg_v_in = 1'b0;
    logic rq0_r, rq1_r, rq0_ov, rq1_ov, tg_v, tg_r, owner, busy;
    logic [7:0] rq0_od, rq1_od, tg_d;

    always #5 clk = ~clk;

    bp_arb2 dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg),
        .i_req0_data(rq0_d), .i_req0_valid(rq0_v), .o_req0_ready(rq0_r),
        .o_req0_data(rq0_od), .o_req0_valid(rq0_ov), .i_req0_ready(rq0_rin),
        .i_req1_data(rq1_d), .i_req1_valid(rq1_v), .o_req1_ready(rq1_r),
        .o_req1_data(rq1_od), .o_req1_valid(rq1_ov), .i_req1_ready(rq1_rin),
        .o_tgt_data(tg_d), .o_tgt_valid(tg_v), .i_tgt_ready(tg_rdy_in),
        .i_tgt_data(tg_d_in), .i_tgt_valid(tg_v_in), .o_tgt_ready(tg_r),
        .o_owner(owner), .o_busy(busy)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] txq0[$], txq1[$], rspq[$], tgt_log[$];
    int cmd_log[$];
    int resp_cnt[2];
    int exp_resp[2];
    int busy_cnt;
    bit seen_rdy0, seen_rdy1, rand_en;

    // Target-side view of the byte stream, following the framing rules.
    bit m_in_txn, m_locked, m_wr, m_a0;
    int m_src, m_lock_src, m_data_left, m_resp_left, m_hold;
    logic [7:0] m_burst;
    logic exp_owner;

    task automatic model_clear();
        m_in_txn = 0; m_locked = 0; m_wr = 0; m_a0 = 0;
        m_src = 0; m_lock_src = 0; m_data_left = 0; m_resp_left = 0; m_hold = 0;
        m_burst = 8'd0; exp_owner = 1'b0;
        txq0.delete(); txq1.delete(); rspq.delete(); tgt_log.delete(); cmd_log.delete();
        resp_cnt[0] = 0; resp_cnt[1] = 0; exp_resp[0] = 0; exp_resp[1] = 0;
        busy_cnt = 0; seen_rdy0 = 0; seen_rdy1 = 0;
    endtask

    task automatic push(int r, logic [7:0] b);
        if (r == 1) txq1.push_back(b); else txq0.push_back(b);
    endtask

    task automatic schedule(int n);
        m_resp_left = n;
        m_hold = 1;
        repeat (n) rspq.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic model_byte(int src, logic [7:0] b);
        int nb;
        if (!m_in_txn) begin
            checks++;
            if (m_locked && src != m_lock_src) begin
                errors++; $display("FAIL lock_owner: got %0d expected %0d", src, m_lock_src);
            end
            m_locked = 0; m_in_txn = 1; m_src = src; exp_owner = 1'(src);
            m_wr = b[7]; m_a0 = (b[6:0] == 7'd0);
            nb = (m_a0 ? 0 : int'(m_burst)) + 1;
            cmd_log.push_back(src);
            if (m_wr) m_data_left = nb; else schedule(nb);
        end else begin
            checks++;
            if (src != m_src || m_data_left == 0) begin
                errors++; $display("FAIL framing: src %0d owner %0d data_left %0d", src, m_src, m_data_left);
            end else begin
                if (m_a0) m_burst = b;
                m_data_left--;
                if (m_data_left == 0) schedule(1);
            end
        end
    endtask

    task automatic end_txn();
        m_in_txn = 0;
        if (!m_a0) m_burst = 8'd0;
        if (m_wr && m_a0 && m_burst != 8'd0) begin
            m_locked = 1; m_lock_src = m_src;
        end
    endtask

    // One clock: drive after the falling edge, check and update the model, then cross the edge.
    task automatic step();
        bit in_rsp, exp_r;
        int src;
        logic [7:0] head;
        rq0_v = (txq0.size() > 0) && !(rand_en && $urandom_range(0, 3) == 0);
        rq0_d = (txq0.size() > 0) ? txq0[0] : 8'($urandom);
        rq1_v = (txq1.size() > 0) && !(rand_en && $urandom_range(0, 3) == 0);
        rq1_d = (txq1.size() > 0) ? txq1[0] : 8'($urandom);
        tg_rdy_in = !rand_en || ($urandom_range(0, 3) != 0);
        rq0_rin   = !rand_en || ($urandom_range(0, 3) != 0);
        rq1_rin   = !rand_en || ($urandom_range(0, 3) != 0);
        if (rspq.size() > 0) begin
            tg_v_in = (m_hold == 0) && (!rand_en || $urandom_range(0, 3) != 0);
            tg_d_in = rspq[0];
        end else begin
            tg_v_in = rand_en && ($urandom_range(0, 7) == 0);
            tg_d_in = 8'($urandom);
        end
        if (m_hold > 0) m_hold--;
        #1;
        checks++;
        if (busy !== (m_in_txn || m_locked)) begin
            errors++; $display("FAIL busy: got %0b expected %0b", busy, (m_in_txn || m_locked));
        end
        checks++;
        if (owner !== exp_owner) begin
            errors++; $display("FAIL owner: got %0b expected %0b", owner, exp_owner);
        end
        if (busy === 1'b1) busy_cnt++;
        if (rq0_r === 1'b1) seen_rdy0 = 1;
        if (rq1_r === 1'b1) seen_rdy1 = 1;
        checks++;
        if ((rq0_r && rq1_r) || (rq0_ov && rq1_ov)) begin
            errors++; $display("FAIL exclusive: rdy %0b%0b vld %0b%0b expected one-hot", rq1_r, rq0_r, rq1_ov, rq0_ov);
        end
        in_rsp = m_in_txn && (m_resp_left > 0);
        if (tg_v && tg_rdy_in) begin
            src = rq1_r ? 1 : 0;
            head = (src == 1) ? ((txq1.size() > 0) ? txq1[0] : 8'hxx) : ((txq0.size() > 0) ? txq0[0] : 8'hxx);
            checks++;
            if ((src == 1 ? (rq1_v && rq1_r) : (rq0_v && rq0_r)) !== 1'b1 || tg_d !== head) begin
                errors++; $display("FAIL tgt_byte: got %0h from req%0d expected %0h", tg_d, src, head);
            end else begin
                if (src == 1) void'(txq1.pop_front()); else void'(txq0.pop_front());
                tgt_log.push_back(tg_d);
                model_byte(src, tg_d);
            end
        end else begin
            checks++;
            if ((rq0_r && rq0_v) || (rq1_r && rq1_v)) begin
                errors++; $display("FAIL req_handshake: ready %0b%0b without target accept, expected none", rq1_r, rq0_r);
            end
        end
        if (tg_v_in) begin
            exp_r = in_rsp ? (m_src == 1 ? rq1_rin : rq0_rin) : 1'b0;
            checks++;
            if (tg_r !== exp_r) begin
                errors++; $display("FAIL tgt_ready: got %0b expected %0b", tg_r, exp_r);
            end
        end
        if (tg_v_in && tg_r && in_rsp) begin
            checks++;
            if (m_src == 1 ? (rq1_ov !== 1'b1 || rq1_od !== tg_d_in || rq0_ov !== 1'b0)
                           : (rq0_ov !== 1'b1 || rq0_od !== tg_d_in || rq1_ov !== 1'b0)) begin
                errors++; $display("FAIL resp_route: vld %0b%0b data %0h/%0h expected req%0d data %0h",
                                   rq1_ov, rq0_ov, rq1_od, rq0_od, m_src, tg_d_in);
            end
            void'(rspq.pop_front());
            resp_cnt[m_src]++;
            m_resp_left--;
            if (m_resp_left == 0) end_txn();
        end else begin
            checks++;
            if ((rq0_ov && rq0_rin) || (rq1_ov && rq1_rin)) begin
                errors++; $display("FAIL resp_handshake: vld %0b%0b without target accept, expected none", rq1_ov, rq0_ov);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(int max);
        int n = 0;
        while ((txq0.size() > 0 || txq1.size() > 0 || m_in_txn || m_locked) && n < max) begin
            step();
            n++;
        end
        checks++;
        if (txq0.size() > 0 || txq1.size() > 0 || m_in_txn || m_locked) begin
            errors++; $display("FAIL timeout: pending %0d/%0d bytes after %0d cycles, expected drained", txq0.size(), txq1.size(), n);
        end
        rq0_v = 0; rq1_v = 0; tg_v_in = 0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL idle_end: busy %0b expected 0", busy);
        end
    endtask

    task automatic do_reset();
        rq0_v = 0; rq1_v = 0; tg_v_in = 0; tg_rdy_in = 0; rq0_rin = 0; rq1_rin = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
    endtask

    task automatic test_reset();
        rand_en = 0;
        do_reset();
        #1;
        checks++;
        if ({busy, owner, rq0_ov, rq1_ov, tg_v, tg_r, rq0_r, rq1_r} !== 8'h00) begin
            errors++; $display("FAIL reset: outputs %b expected 00000000", {busy, owner, rq0_ov, rq1_ov, tg_v, tg_r, rq0_r, rq1_r});
        end
    endtask

    task automatic test_read_alone();
        do_reset();
        push(0, 8'h05);
        run(40);
        checks++;
        if (tgt_log.size() != 1 || tgt_log[0] !== 8'h05 || resp_cnt[0] != 1 || resp_cnt[1] != 0) begin
            errors++; $display("FAIL read_alone: %0d bytes, resp %0d/%0d expected 1 byte 05, resp 1/0", tgt_log.size(), resp_cnt[0], resp_cnt[1]);
        end
        checks++;
        if (busy_cnt < 2) begin
            errors++; $display("FAIL read_busy: %0d cycles expected >=2", busy_cnt);
        end
    endtask

    task automatic test_write_req1();
        do_reset();
        push(1, 8'h83); push(1, 8'hAA);
        run(40);
        checks++;
        if (tgt_log.size() != 2 || tgt_log[0] !== 8'h83 || tgt_log[1] !== 8'hAA || resp_cnt[1] != 1 || resp_cnt[0] != 0) begin
            errors++; $display("FAIL write_req1: %0d bytes, resp %0d/%0d expected 83 AA, resp 0/1", tgt_log.size(), resp_cnt[0], resp_cnt[1]);
        end
        checks++;
        if (seen_rdy0) begin
            errors++; $display("FAIL req0_ready: seen 1 expected 0");
        end
    endtask

    task automatic test_lock();
        do_reset();
        push(0, 8'h80); push(0, 8'h03); push(0, 8'h07);
        push(1, 8'h05);
        run(80);
        checks++;
        if (cmd_log.size() != 3 || cmd_log[0] != 0 || cmd_log[1] != 0 || cmd_log[2] != 1) begin
            errors++; $display("FAIL lock_order: %0d cmds expected order 0,0,1", cmd_log.size());
        end
        checks++;
        if (resp_cnt[0] != 5 || resp_cnt[1] != 1) begin
            errors++; $display("FAIL lock_resp: %0d/%0d expected 5/1", resp_cnt[0], resp_cnt[1]);
        end
    endtask

    task automatic test_burst_write();
        logic [7:0] exp_b[8];
        exp_b = '{8'h80, 8'h02, 8'h81, 8'h11, 8'h22, 8'h33, 8'h81, 8'h44};
        do_reset();
        foreach (exp_b[i]) push(0, exp_b[i]);
        run(80);
        checks++;
        if (tgt_log.size() != 8 || resp_cnt[0] != 3) begin
            errors++; $display("FAIL burst_count: %0d bytes %0d resp expected 8 bytes 3 resp", tgt_log.size(), resp_cnt[0]);
        end else begin
            foreach (exp_b[i]) begin
                checks++;
                if (tgt_log[i] !== exp_b[i]) begin
                    errors++; $display("FAIL burst_byte%0d: got %0h expected %0h", i, tgt_log[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_tie();
        int exp_src[4];
`ifdef BP_ARB2_ROUNDROBIN_EN
        exp_src = '{0, 1, 0, 1};
`else
        exp_src = '{0, 0, 0, 0};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 8'(8'h01 + i));
            push(1, 8'(8'h11 + i));
        end
        run(120);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_log.size() <= i || cmd_log[i] != exp_src[i]) begin
                errors++; $display("FAIL tie%0d: got %0d expected %0d", i, (cmd_log.size() > i) ? cmd_log[i] : -1, exp_src[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        push(0, 8'h80); push(0, 8'h01); push(0, 8'h81);
        while (tgt_log.size() < 3 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (tgt_log.size() != 3 || m_data_left != 2) begin
            errors++; $display("FAIL mid_setup: %0d bytes data_left %0d expected 3 and 2", tgt_log.size(), m_data_left);
        end
        txq0.delete(); rspq.delete();
        rq0_v = 0; rq1_v = 0; tg_v_in = 0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({busy, owner, rq0_ov, rq1_ov, tg_v} !== 5'b0) begin
            errors++; $display("FAIL mid_reset: outputs %b expected 00000", {busy, owner, rq0_ov, rq1_ov, tg_v});
        end
        rst = 0;
        model_clear();
        push(0, 8'h81); push(0, 8'h55);
        run(40);
        checks++;
        if (tgt_log.size() != 2 || tgt_log[1] !== 8'h55 || resp_cnt[0] != 1) begin
            errors++; $display("FAIL mid_burst0: %0d bytes %0d resp expected 2 bytes 1 resp", tgt_log.size(), resp_cnt[0]);
        end
    endtask

    task automatic gen_unit(int r);
        int k, n;
        logic [7:0] a;
        k = $urandom_range(0, 3);
        a = 8'($urandom_range(1, 127));
        case (k)
            0: begin push(r, a); exp_resp[r] += 1; end
            1: begin push(r, 8'h80 | a); push(r, 8'($urandom)); exp_resp[r] += 1; end
            2: begin push(r, 8'h00); exp_resp[r] += 1; end
            default: begin
                n = $urandom_range(0, 4);
                push(r, 8'h80); push(r, 8'(n)); exp_resp[r] += 1;
                if ($urandom_range(0, 1) == 0) begin
                    push(r, a); exp_resp[r] += n + 1;
                end else begin
                    push(r, 8'h80 | a);
                    repeat (n + 1) push(r, 8'($urandom));
                    exp_resp[r] += 1;
                end
            end
        endcase
    endtask

    task automatic test_random();
        for (int round = 0; round < 3; round++) begin
            rand_en = 0;
            do_reset();
            rand_en = 1;
            for (int u = 0; u < 25; u++) begin
                gen_unit(0);
                gen_unit(1);
            end
            run(20000);
            checks++;
            if (resp_cnt[0] != exp_resp[0] || resp_cnt[1] != exp_resp[1]) begin
                errors++; $display("FAIL rand_resp%0d: %0d/%0d expected %0d/%0d", round, resp_cnt[0], resp_cnt[1], exp_resp[0], exp_resp[1]);
            end
        end
        rand_en = 0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_read_alone();
        test_write_req1();
        test_lock();
        test_burst_write();
        test_tie();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
